// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (serial double-dabble, one bit per clock).
// Digits and the leading-zero mask are registered and only change when a conversion completes.
module bin2bcd_seq (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd4,
  output logic [4:0]  blank
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_next;
  logic [35:0] sr, sr_adj, sr_next;
  logic [3:0]  cnt, cnt_next;
  logic        load_result;
  logic [4:0]  blank_next;

  // Add-3 correction on the five BCD fields above the binary operand
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < 5; i++) begin
      if (sr[16+4*i +: 4] >= 4'd5)
        sr_adj[16+4*i +: 4] = sr[16+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_next  = state;
    sr_next     = sr;
    cnt_next    = cnt;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sr_next    = {20'b0, bin};
          cnt_next   = 4'd0;
          state_next = CONV;
        end
      end
      CONV: begin
        sr_next  = {sr_adj[34:0], 1'b0};
        cnt_next = cnt + 4'd1;
        if (cnt == 4'd15) begin
          state_next  = IDLE;
          load_result = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A digit is blanked when it and every more significant digit are zero
  always_comb begin
    blank_next    = 5'b0;
    blank_next[4] = (sr_next[35:32] == 4'd0);
    blank_next[3] = blank_next[4] && (sr_next[31:28] == 4'd0);
    blank_next[2] = blank_next[3] && (sr_next[27:24] == 4'd0);
    blank_next[1] = blank_next[2] && (sr_next[23:20] == 4'd0);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= IDLE;
      sr    <= 36'd0;
      cnt   <= 4'd0;
      done  <= 1'b0;
      bcd0  <= 4'd0;
      bcd1  <= 4'd0;
      bcd2  <= 4'd0;
      bcd3  <= 4'd0;
      bcd4  <= 4'd0;
      blank <= 5'b11110;
    end else begin
      state <= state_next;
      sr    <= sr_next;
      cnt   <= cnt_next;
      done  <= load_result;
      if (load_result) begin
        bcd0  <= sr_next[19:16];
        bcd1  <= sr_next[23:20];
        bcd2  <= sr_next[27:24];
        bcd3  <= sr_next[31:28];
        bcd4  <= sr_next[35:32];
        blank <= blank_next;
      end
    end
  end

  assign busy = (state == CONV);

endmodule
